// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: FSM states,
// cause one-hot codes and vector-table offsets.
package exc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_RD_HI  = 3'd2,
        S_RD_LO  = 3'd3,
        S_CAP_LO = 3'd4,
        S_JUMP   = 3'd5
    } state_t;

    localparam logic [3:0] CAUSE_NONE  = 4'b0000;
    localparam logic [3:0] CAUSE_STACK = 4'b0001;
    localparam logic [3:0] CAUSE_ADDR  = 4'b0010;
    localparam logic [3:0] CAUSE_INT   = 4'b0100;

    localparam logic [31:0] K_STACK = 32'd1;
    localparam logic [31:0] K_ADDR  = 32'd2;
    localparam logic [31:0] K_INT   = 32'd3;

    // Request/grant bit order: [2] addr, [1] stack, [0] int.
    localparam int REQ_ADDR  = 2;
    localparam int REQ_STACK = 1;
    localparam int REQ_INT   = 0;

    function automatic logic [3:0] grant_to_cause(input logic [2:0] grant);
        logic [3:0] cause;
        cause = CAUSE_NONE;
        case (grant)
            3'b100:  cause = CAUSE_ADDR;
            3'b010:  cause = CAUSE_STACK;
            3'b001:  cause = CAUSE_INT;
            default: cause = CAUSE_NONE;
        endcase
        return cause;
    endfunction

    // Each vector entry is two 16-bit words, so the word offset is 2*k.
    function automatic logic [31:0] grant_to_offset(input logic [2:0] grant);
        logic [31:0] k;
        k = 32'd0;
        case (grant)
            3'b100:  k = K_ADDR;
            3'b010:  k = K_STACK;
            3'b001:  k = K_INT;
            default: k = 32'd0;
        endcase
        return k << 1;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder for exception sources: addr > stack > int.
// Produces a one-hot grant (all zero when nothing is requested).
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        if (req[REQ_ADDR])
            grant[REQ_ADDR] = 1'b1;
        else if (req[REQ_STACK])
            grant[REQ_STACK] = 1'b1;
        else if (req[REQ_INT])
            grant[REQ_INT] = 1'b1;
    end

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer: flushes the pipeline, fetches the handler
// address from a two-word vector entry and loads it into the PC.
// Optional feature: define EXC_PENDING_EN to remember events that were not
// accepted (simultaneous lower-priority or arriving while busy).
//
// state  | meaning
// IDLE   | waiting for an event; accepts highest-priority source
// FLUSH  | squash pipeline, cause and epc already latched
// RD_HI  | read vector word vec
// RD_LO  | read vector word vec+1, capture high half
// CAP_LO | capture low half, prepare PC load
// JUMP   | one-cycle pc_load with handler address
module exc_sequencer
    import exc_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_exc,
    input  logic        stack_exc,
    input  logic        int_req,
    input  logic [31:0] pc_in,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  exceptions,
    output logic        flush,
    output logic        stall,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic        pc_load,
    output logic [31:0] pc_value,
    output logic [31:0] epc,
    output logic        busy
);

    state_t      state;
    logic [31:0] vec;
    logic [15:0] hi;
    logic [2:0]  req_live;
    logic [2:0]  req;
    logic [2:0]  grant;

    assign req_live = {addr_exc, stack_exc, int_req};

`ifdef EXC_PENDING_EN
    logic [2:0] pending;

    assign req = req_live | pending;

    // Granted source is retired on the accepting edge; everything else sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= 3'b000;
        else if (state == S_IDLE)
            pending <= (pending | req_live) & ~grant;
        else
            pending <= pending | req_live;
    end
`else
    assign req = req_live;
`endif

    exc_prio_enc u_prio (
        .req   (req),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            vec        <= 32'd0;
            hi         <= 16'd0;
            exceptions <= CAUSE_NONE;
            flush      <= 1'b0;
            stall      <= 1'b0;
            busy       <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= 32'd0;
            pc_load    <= 1'b0;
            pc_value   <= 32'd0;
            epc        <= 32'd0;
        end else begin
            flush    <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= 32'd0;
            pc_load  <= 1'b0;
            pc_value <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state      <= S_FLUSH;
                        exceptions <= grant_to_cause(grant);
                        epc        <= pc_in;
                        vec        <= VEC_BASE + grant_to_offset(grant);
                        flush      <= 1'b1;
                        stall      <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    state    <= S_RD_HI;
                    mem_rd   <= 1'b1;
                    mem_addr <= vec;
                end
                S_RD_HI: begin
                    state    <= S_RD_LO;
                    mem_rd   <= 1'b1;
                    mem_addr <= vec + 32'd1;
                end
                S_RD_LO: begin
                    state <= S_CAP_LO;
                    hi    <= mem_rdata;
                end
                S_CAP_LO: begin
                    // Low half lands directly in pc_value, which is only
                    // visible during JUMP.
                    state    <= S_JUMP;
                    pc_load  <= 1'b1;
                    pc_value <= {hi, mem_rdata};
                end
                S_JUMP: begin
                    state      <= S_IDLE;
                    exceptions <= CAUSE_NONE;
                    stall      <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    exceptions <= CAUSE_NONE;
                    stall      <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: scoreboard of expected vector reads and
// PC loads, checked by a negedge monitor; two instances cover VEC_BASE wrap.
module tb_exc_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        addr_exc, stack_exc, int_req;
    logic [31:0] pc_in;
    logic [15:0] mem_rdata0;
    logic [3:0]  exceptions0;
    logic        flush0, stall0, mem_rd0, pc_load0, busy0;
    logic [31:0] mem_addr0, pc_value0, epc0;

    logic        zero1 = 1'b0;
    logic        int_req1;
    logic [31:0] pc_in1;
    logic [15:0] mem_rdata1;
    logic [3:0]  exceptions1;
    logic        flush1, stall1, mem_rd1, pc_load1, busy1;
    logic [31:0] mem_addr1, pc_value1, epc1;

    exc_sequencer #(.VEC_BASE(32'h0000_0000)) dut0 (
        .clk(clk), .reset(reset), .addr_exc(addr_exc), .stack_exc(stack_exc),
        .int_req(int_req), .pc_in(pc_in), .mem_rdata(mem_rdata0),
        .exceptions(exceptions0), .flush(flush0), .stall(stall0),
        .mem_rd(mem_rd0), .mem_addr(mem_addr0), .pc_load(pc_load0),
        .pc_value(pc_value0), .epc(epc0), .busy(busy0)
    );

    exc_sequencer #(.VEC_BASE(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(reset), .addr_exc(zero1), .stack_exc(zero1),
        .int_req(int_req1), .pc_in(pc_in1), .mem_rdata(mem_rdata1),
        .exceptions(exceptions1), .flush(flush1), .stall(stall1),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .pc_load(pc_load1),
        .pc_value(pc_value1), .epc(epc1), .busy(busy1)
    );

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        logic [15:0] w;
        case (a)
            32'd2:   w = 16'h0001;
            32'd3:   w = 16'h2000;
            default: w = a[15:0] ^ 16'hA5A5;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        mem_rdata0 <= mem_rd0 ? mem_word(mem_addr0) : 16'h0000;
        mem_rdata1 <= mem_rd1 ? mem_word(mem_addr1) : 16'h0000;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
        logic [31:0] exc;
    } jump_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] addr_q0[$];
    logic [31:0] addr_q1[$];
    jump_t       jump_q0[$];
    jump_t       jump_q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_seq0(input logic [31:0] vec, input logic [31:0] e, input logic [3:0] exc);
        jump_t j;
        addr_q0.push_back(vec);
        addr_q0.push_back(vec + 32'd1);
        j.pc  = {mem_word(vec), mem_word(vec + 32'd1)};
        j.epc = e;
        j.exc = {28'd0, exc};
        jump_q0.push_back(j);
    endtask

    // Monitor: every vector read and PC load must match the scoreboard head.
    always @(negedge clk) begin
        jump_t j;
        if (mem_rd0) begin
            n_checks++;
            assert (addr_q0.size() > 0) else begin
                n_fail++;
                $error("FAIL dut0_unexpected_rd: observed addr %h expected none", mem_addr0);
            end
            if (addr_q0.size() > 0) chk("dut0_mem_addr", mem_addr0, addr_q0.pop_front());
        end else if (reset) begin
            chk("dut0_addr_unqualified", mem_addr0, 32'd0);
        end
        if (pc_load0) begin
            n_checks++;
            assert (jump_q0.size() > 0) else begin
                n_fail++;
                $error("FAIL dut0_unexpected_pc_load: observed pc %h expected none", pc_value0);
            end
            if (jump_q0.size() > 0) begin
                j = jump_q0.pop_front();
                chk("dut0_pc_value", pc_value0, j.pc);
                chk("dut0_epc", epc0, j.epc);
                chk("dut0_exceptions", {28'd0, exceptions0}, j.exc);
            end
        end else if (reset) begin
            chk("dut0_pc_unqualified", pc_value0, 32'd0);
        end
        if (mem_rd1) begin
            n_checks++;
            assert (addr_q1.size() > 0) else begin
                n_fail++;
                $error("FAIL dut1_unexpected_rd: observed addr %h expected none", mem_addr1);
            end
            if (addr_q1.size() > 0) chk("dut1_mem_addr", mem_addr1, addr_q1.pop_front());
        end
        if (pc_load1) begin
            n_checks++;
            assert (jump_q1.size() > 0) else begin
                n_fail++;
                $error("FAIL dut1_unexpected_pc_load: observed pc %h expected none", pc_value1);
            end
            if (jump_q1.size() > 0) begin
                j = jump_q1.pop_front();
                chk("dut1_pc_value", pc_value1, j.pc);
                chk("dut1_epc", epc1, j.epc);
                chk("dut1_exceptions", {28'd0, exceptions1}, j.exc);
            end
        end
    end

    // Counts negedges until pc_load0 (bounded); returns -1 on timeout.
    task automatic wait_pcload0(output int cyc, output int nflush);
        cyc = -1;
        nflush = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (flush0) nflush++;
            if (pc_load0) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nf, nlow, npl;
        logic [31:0] lowmask;
        jump_t j;

        reset = 1'b0; addr_exc = 0; stack_exc = 0; int_req = 0; pc_in = 0;
        int_req1 = 0; pc_in1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_exceptions", {28'd0, exceptions0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_stall", {31'd0, stall0}, 32'd0);
        chk("rst_epc", epc0, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Stack exception, handler 0x0001_2000
        stack_exc = 1; pc_in = 32'h0000_0040;
        push_seq0(32'd2, 32'h40, 4'b0001);
        @(posedge clk); #1;
        stack_exc = 0; pc_in = 32'h0;
        chk("stack_exc_cause", {28'd0, exceptions0}, 32'h1);
        chk("stack_busy", {31'd0, busy0}, 32'd1);
        wait_pcload0(cyc, nf);
        chk("stack_latency", cyc, 32'd5);
        chk("stack_flush_cycles", nf, 32'd1);
        chk("stack_epc_hold", epc0, 32'h40);
        @(negedge clk);
        chk("stack_back_idle", {31'd0, busy0}, 32'd0);
        chk("stack_cause_clear", {28'd0, exceptions0}, 32'd0);

        // Simultaneous addr + int: addr wins
        @(negedge clk);
        addr_exc = 1; int_req = 1; pc_in = 32'h0000_0100;
        push_seq0(32'd4, 32'h100, 4'b0010);
`ifdef EXC_PENDING_EN
        push_seq0(32'd6, 32'h100, 4'b0100);
`endif
        @(posedge clk); #1;
        addr_exc = 0; int_req = 0;
        chk("prio_cause", {28'd0, exceptions0}, 32'h2);
        wait_pcload0(cyc, nf);
        chk("prio_latency", cyc, 32'd5);
`ifdef EXC_PENDING_EN
        wait_pcload0(cyc, nf);
        chk("pending_latency", cyc, 32'd6);
`endif
        repeat (8) @(negedge clk);
        chk("prio_idle_after", {31'd0, busy0}, 32'd0);
        chk("prio_queue_drained", jump_q0.size(), 32'd0);

        // Reset in RD_LO
        int_req = 1; pc_in = 32'h0000_0200;
        addr_q0.push_back(32'd6);
        @(posedge clk); #1;
        int_req = 0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("arst_exceptions", {28'd0, exceptions0}, 32'd0);
        chk("arst_flush", {31'd0, flush0}, 32'd0);
        chk("arst_stall", {31'd0, stall0}, 32'd0);
        chk("arst_mem_rd", {31'd0, mem_rd0}, 32'd0);
        chk("arst_mem_addr", mem_addr0, 32'd0);
        chk("arst_pc_load", {31'd0, pc_load0}, 32'd0);
        chk("arst_pc_value", pc_value0, 32'd0);
        chk("arst_epc", epc0, 32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_no_restart", {31'd0, busy0}, 32'd0);
        int_req = 1; pc_in = 32'h0000_0300;
        push_seq0(32'd6, 32'h300, 4'b0100);
        @(posedge clk); #1;
        int_req = 0;
        chk("arst_restart_flush", {31'd0, flush0}, 32'd1);
        wait_pcload0(cyc, nf);
        chk("arst_restart_latency", cyc, 32'd5);

        // Vector address wrap on dut1
        @(negedge clk);
        int_req1 = 1; pc_in1 = 32'h0000_0077;
        addr_q1.push_back(32'h0000_0002);
        addr_q1.push_back(32'h0000_0003);
        j.pc = 32'h0001_2000; j.epc = 32'h77; j.exc = 32'h4;
        jump_q1.push_back(j);
        @(posedge clk); #1;
        int_req1 = 0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pc_load1) begin
                cyc = i;
                break;
            end
        end
        chk("wrap_latency", cyc, 32'd5);

        // Held interrupt: back-to-back sequences with one IDLE cycle between
        @(negedge clk);
        int_req = 1; pc_in = 32'h0000_0500;
        push_seq0(32'd6, 32'h500, 4'b0100);
        push_seq0(32'd6, 32'h500, 4'b0100);
        push_seq0(32'd6, 32'h500, 4'b0100);
`ifdef EXC_PENDING_EN
        push_seq0(32'd6, 32'h500, 4'b0100);
`endif
        @(posedge clk);
        nlow = 0; npl = 0; lowmask = 32'd0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (!busy0) begin
                nlow++;
                lowmask = lowmask | (32'd1 << i);
            end
            if (pc_load0) npl++;
        end
        int_req = 0;
        chk("held_idle_count", nlow, 32'd2);
        chk("held_idle_position", lowmask, (32'd1 << 6) | (32'd1 << 12));
        chk("held_pc_loads", npl, 32'd3);

        repeat (14) @(negedge clk);
        chk("final_busy", {31'd0, busy0}, 32'd0);
        chk("final_addr_q0", addr_q0.size(), 32'd0);
        chk("final_jump_q0", jump_q0.size(), 32'd0);
        chk("final_addr_q1", addr_q1.size(), 32'd0);
        chk("final_jump_q1", jump_q1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 SHALL have parameter VEC_BASE, default 32'h0000_0000, meaning the word address of the vector table.
REQ-002 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-004 SHALL have port addr_exc, input, width 1: invalid memory address detected this cycle.
REQ-005 SHALL have port stack_exc, input, width 1: empty-stack pop detected this cycle.
REQ-006 SHALL have port int_req, input, width 1: external interrupt request, level-sampled.
REQ-007 SHALL have port pc_in, input, width 32: PC of the faulting or interrupted instruction.
REQ-008 SHALL have port mem_rdata, input, width 16: instruction-memory read data, valid the cycle after mem_rd.
REQ-009 SHALL have port exceptions, output, width 4: one-hot cause to the control unit (0001 stack, 0010 address, 0100 interrupt, 0000 none).
REQ-010 SHALL have port flush, output, width 1: squash the IF/ID/EX pipeline registers.
REQ-011 SHALL have port stall, output, width 1: freeze the PC and fetch while the sequencer is busy.
REQ-012 SHALL have port mem_rd / mem_addr, output, width 1 / 32: vector-table read request and word address.
REQ-013 SHALL have port pc_load / pc_value, output, width 1 / 32: one-cycle PC overwrite with the handler address.
REQ-014 SHALL have port epc, output, width 32: saved pc_in of the accepted event, held until the next acceptance.
REQ-015 SHALL have port busy, output, width 1: high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM IDLE -> FLUSH -> RD_HI -> RD_LO -> CAP_LO -> JUMP -> IDLE, one cycle per non-IDLE state.
REQ-017 SHALL, in IDLE, accept an event when any source is high, with priority addr_exc > stack_exc > int_req; on the accepting edge, latch cause and epc <= pc_in.
REQ-018 SHALL hold exceptions at the cause one-hot from FLUSH through JUMP, and at 0000 in IDLE.
REQ-019 SHALL assert flush in FLUSH only, and stall in all states FLUSH..JUMP.
REQ-020 SHALL use vector word address vec = VEC_BASE + 2*k, where k = 1 for stack, 2 for address and 3 for interrupt; all address arithmetic is modulo 2^32.
REQ-021 SHALL, in RD_HI, drive mem_rd=1 and mem_addr=vec; in RD_LO, drive mem_rd=1 and mem_addr=vec+1 and capture hi <= mem_rdata; in CAP_LO, capture lo <= mem_rdata.
REQ-022 SHALL, in JUMP, assert pc_load=1 with pc_value={hi,lo}, so that pc_load is high exactly 5 cycles after the accepting edge.
REQ-023 SHALL register all outputs; mem_addr and pc_value are 0 when not qualified by mem_rd or pc_load.
REQ-024 SHALL, without the macro, ignore lower-priority events simultaneous with the accepted event and any event arriving while busy.
REQ-025 SHALL, on JUMP -> IDLE, re-evaluate sources in IDLE on the next edge (no back-to-back skip of IDLE).

Reset
REQ-026 SHALL, on reset low (asynchronous, any state including mid-sequence), force IDLE and drive all outputs, epc, hi, lo and the pending bits to 0.
REQ-027 SHALL restart sequencing only on events sampled after reset deasserts.

Configuration
REQ-028 SHALL, with EXC_PENDING_EN defined, OR any non-accepted or busy-time event into pending[2:0] (addr, stack, int); IDLE then accepts (live | pending) using REQ-017 priority, and the accepted bit is cleared in the same edge; epc takes pc_in at acceptance.
REQ-029 SHALL, without EXC_PENDING_EN, contain no pending register and behave per REQ-024.

Structure
REQ-030 SHALL place the state enum, the cause one-hot constants and the vector offsets k in the shared package exc_pkg.
REQ-031 SHALL implement priority selection in one sub-module, exc_prio_enc (3-bit request in, one-hot 3-bit grant out).

Verification
REQ-032 SHALL cover: VEC_BASE=0, stack_exc pulse with pc_in=32'h0000_0040, mem words @2=16'h0001, @3=16'h2000 -> exceptions=0001, flush 1 cycle, pc_load 5 cycles later with pc_value=32'h0001_2000, epc=32'h40.
REQ-033 SHALL cover: addr_exc and int_req high on the same cycle -> mem_addr 4 then 5, exceptions=0010; int dropped (no macro), or served immediately after IDLE with mem_addr 6 then 7 (macro).
REQ-034 SHALL cover: reset low during RD_LO -> all outputs 0 immediately, state IDLE, no pc_load; a new int_req after release -> full sequence from FLUSH.
REQ-035 SHALL cover: VEC_BASE=32'hFFFF_FFFC, int_req -> mem_addr 32'hFFFF_FFFC+6 wraps to 32'h0000_0002, then 32'h0000_0003.
REQ-036 SHALL cover: int_req held high continuously -> consecutive sequences separated by exactly one IDLE cycle; busy low only in that cycle.
